// File: rtl/mcntrl_chnbuf_rd_if.sv
// rtl/mcntrl_chnbuf_rd_if.sv - channel read buffer write/read/status bundle
// CHNBUF_RD_ABORT_EN adds the rd_abort request line.
interface mcntrl_chnbuf_rd_if #(
    parameter int NUM_PAGES_LOG2 = 2
);
    logic                    buf_wr_chn;
    logic [6:0]              buf_waddr_chn;
    logic [63:0]             buf_wdata_chn;
    logic                    buf_done;
    logic                    xfer_want;
    logic                    page_ready;
    logic                    rd_start;
    logic                    rd_en;
    logic [31:0]             rd_data;
    logic                    rd_valid;
    logic                    rd_page_done;
    logic [NUM_PAGES_LOG2:0] pages_full;
    logic                    overflow;
`ifdef CHNBUF_RD_ABORT_EN
    logic                    rd_abort;
`endif

    modport master (
`ifdef CHNBUF_RD_ABORT_EN
        output rd_abort,
`endif
        output buf_wr_chn, buf_waddr_chn, buf_wdata_chn, buf_done,
        output rd_start, rd_en,
        input  xfer_want, page_ready, rd_data, rd_valid, rd_page_done,
        input  pages_full, overflow
    );

    modport slave (
`ifdef CHNBUF_RD_ABORT_EN
        input  rd_abort,
`endif
        input  buf_wr_chn, buf_waddr_chn, buf_wdata_chn, buf_done,
        input  rd_start, rd_en,
        output xfer_want, page_ready, rd_data, rd_valid, rd_page_done,
        output pages_full, overflow
    );
endinterface

// File: rtl/mcntrl_chnbuf_rd.sv
// rtl/mcntrl_chnbuf_rd.sv - multi-page channel read buffer, 64-bit in, 32-bit out
// CHNBUF_RD_ABORT_EN enables early page release through rd_abort.
module mcntrl_chnbuf_rd #(
    parameter int NUM_PAGES_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    mcntrl_chnbuf_rd_if.slave   bus
);
    localparam int PW    = NUM_PAGES_LOG2 + 1;
    localparam int DEPTH = 2 ** (NUM_PAGES_LOG2 + 7);
    localparam logic [PW-1:0] PAGES_MAX = PW'(2 ** NUM_PAGES_LOG2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } state_t;

    state_t                    state, state_nxt;
    logic [7:0]                raddr, raddr_nxt;
    logic [NUM_PAGES_LOG2-1:0] wpage, rpage;
    logic [PW-1:0]             pages_full, pages_full_nxt;
    logic                      xfer_want_q;
    logic                      overflow_q;
    logic                      rd_page_done_q;
    logic                      full;
    logic                      wr_accept;
    logic                      done_accept;
    logic                      rd_fire;
    logic                      page_release;
    logic                      abort_req;

    logic [63:0]               mem [0:DEPTH-1];
    logic [63:0]               ram_q;
    logic                      ram_v;
    logic                      ram_sel;
    logic [31:0]               rd_data_q;
    logic                      rd_valid_q;

    assign full        = (pages_full == PAGES_MAX);
    assign wr_accept   = bus.buf_wr_chn && !full;
    assign done_accept = bus.buf_done && !full;

`ifdef CHNBUF_RD_ABORT_EN
    assign abort_req = bus.rd_abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        raddr_nxt    = raddr;
        rd_fire      = 1'b0;
        page_release = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.rd_start && (pages_full != '0)) begin
                    state_nxt = S_ACTIVE;
                    raddr_nxt = 8'd0;
                end
            end
            S_ACTIVE: begin
                if (bus.rd_en) begin
                    rd_fire   = 1'b1;
                    raddr_nxt = raddr + 8'd1;
                    if (raddr == 8'hFF) begin
                        state_nxt = S_FLUSH;
                    end
                end
                // An abort still lets a read issued in the same cycle complete.
                if (abort_req) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                page_release = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pages_full_nxt = pages_full;
        case ({done_accept, page_release})
            2'b10:   pages_full_nxt = pages_full + PW'(1);
            2'b01:   pages_full_nxt = pages_full - PW'(1);
            default: pages_full_nxt = pages_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            raddr          <= 8'd0;
            wpage          <= '0;
            rpage          <= '0;
            pages_full     <= '0;
            xfer_want_q    <= 1'b1;
            overflow_q     <= 1'b0;
            rd_page_done_q <= 1'b0;
            ram_v          <= 1'b0;
            ram_sel        <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= 32'd0;
        end else begin
            state          <= state_nxt;
            raddr          <= raddr_nxt;
            pages_full     <= pages_full_nxt;
            xfer_want_q    <= (pages_full_nxt < PAGES_MAX);
            rd_page_done_q <= page_release;
            if (full && (bus.buf_wr_chn || bus.buf_done)) begin
                overflow_q <= 1'b1;
            end
            if (done_accept) begin
                wpage <= wpage + NUM_PAGES_LOG2'(1);
            end
            if (page_release) begin
                rpage <= rpage + NUM_PAGES_LOG2'(1);
            end
            // Second pipeline stage: pick the 32-bit half and register it.
            ram_v      <= rd_fire;
            rd_valid_q <= ram_v;
            if (rd_fire) begin
                ram_sel <= raddr[0];
            end
            if (ram_v) begin
                rd_data_q <= ram_sel ? ram_q[63:32] : ram_q[31:0];
            end
        end
    end

    // Page RAM: no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wpage, bus.buf_waddr_chn}] <= bus.buf_wdata_chn;
        end
        if (rd_fire) begin
            ram_q <= mem[{rpage, raddr[7:1]}];
        end
    end

    assign bus.xfer_want    = xfer_want_q;
    assign bus.page_ready   = (pages_full != '0);
    assign bus.pages_full   = pages_full;
    assign bus.overflow     = overflow_q;
    assign bus.rd_page_done = rd_page_done_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
endmodule

// File: tb/tb_mcntrl_chnbuf_rd.sv
// tb/tb_mcntrl_chnbuf_rd.sv - scoreboard bench for the channel read buffer
module tb_mcntrl_chnbuf_rd;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcntrl_chnbuf_rd_if #(.NUM_PAGES_LOG2(L)) bus ();
    mcntrl_chnbuf_rd #(.NUM_PAGES_LOG2(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rd_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", 64'(bus.rd_data), 64'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_page(input logic [31:0] base);
        for (int i = 0; i < 128; i++) begin
            bus.buf_wr_chn    = 1'b1;
            bus.buf_waddr_chn = 7'(i);
            bus.buf_wdata_chn = {base + 32'(2 * i + 1), base + 32'(2 * i)};
            tick();
        end
        bus.buf_wr_chn = 1'b0;
    endtask

    task automatic pulse_done();
        bus.buf_done = 1'b1;
        tick();
        bus.buf_done = 1'b0;
    endtask

    task automatic read_page(input logic [31:0] base, input bit done_at_flush, input int exp_full);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.rd_en = 1'b1;
            exp_q.push_back(base + 32'(i));
            tick();
            if (i == 0) chk("rd_latency_n1", 64'(bus.rd_valid), 64'd0);
            if (i == 1) chk("rd_latency_n2", 64'(bus.rd_valid), 64'd1);
        end
        bus.rd_en = 1'b0;
        if (done_at_flush) bus.buf_done = 1'b1;
        chk("rd_page_done_early", 64'(bus.rd_page_done), 64'd0);
        tick();
        if (done_at_flush) bus.buf_done = 1'b0;
        chk("rd_page_done", 64'(bus.rd_page_done), 64'd1);
        chk("pages_full_after_release", 64'(bus.pages_full), 64'(exp_full));
        tick();
        chk("rd_page_done_pulse", 64'(bus.rd_page_done), 64'd0);
    endtask

    initial begin
        bus.buf_wr_chn    = 1'b0;
        bus.buf_waddr_chn = 7'd0;
        bus.buf_wdata_chn = 64'd0;
        bus.buf_done      = 1'b0;
        bus.rd_start      = 1'b0;
        bus.rd_en         = 1'b0;
`ifdef CHNBUF_RD_ABORT_EN
        bus.rd_abort      = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pages_full", 64'(bus.pages_full), 64'd0);
        chk("rst_xfer_want", 64'(bus.xfer_want), 64'd1);
        chk("rst_page_ready", 64'(bus.page_ready), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_page_done", 64'(bus.rd_page_done), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        rst = 1'b0;
        tick();

        wr_page(32'hA000_0000);
        pulse_done();
        chk("t1_pages_full", 64'(bus.pages_full), 64'd1);
        chk("t1_page_ready", 64'(bus.page_ready), 64'd1);
        chk("t1_xfer_want", 64'(bus.xfer_want), 64'd1);
        read_page(32'hA000_0000, 1'b0, 0);
        chk("t1_page_ready_after", 64'(bus.page_ready), 64'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wr_page(32'hB000_0000 + (32'(p) << 24));
            pulse_done();
            chk("t2_xfer_want", 64'(bus.xfer_want), (p < 3) ? 64'd1 : 64'd0);
        end
        chk("t2_pages_full", 64'(bus.pages_full), 64'd4);
        chk("t2_no_overflow_yet", 64'(bus.overflow), 64'd0);
        bus.buf_wr_chn    = 1'b1;
        bus.buf_waddr_chn = 7'd0;
        bus.buf_wdata_chn = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.buf_done      = 1'b1;
        tick();
        bus.buf_wr_chn = 1'b0;
        bus.buf_done   = 1'b0;
        chk("t2_overflow", 64'(bus.overflow), 64'd1);
        chk("t2_pages_full_sat", 64'(bus.pages_full), 64'd4);
        chk("t2_xfer_want_full", 64'(bus.xfer_want), 64'd0);
        read_page(32'hB000_0000, 1'b0, 3);
        chk("t2_overflow_sticky", 64'(bus.overflow), 64'd1);

        read_page(32'hB100_0000, 1'b0, 2);
        wr_page(32'hC000_0000);
        read_page(32'hB200_0000, 1'b1, 2);
        read_page(32'hB300_0000, 1'b0, 1);
        read_page(32'hC000_0000, 1'b0, 0);

        chk("t4_page_ready", 64'(bus.page_ready), 64'd0);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        bus.rd_en    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_idle_rd_valid", 64'(bus.rd_valid), 64'd0);
        end
        bus.rd_en = 1'b0;
        tick();
        tick();
        chk("t4_idle_rd_valid_tail", 64'(bus.rd_valid), 64'd0);

        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                wr_page(32'hE000_0000);
                pulse_done();
            end else begin
                fork
                    begin
                        wr_page(32'hE000_0000 + (32'(k) << 20));
                        pulse_done();
                    end
                    read_page(32'hE000_0000 + (32'(k - 1) << 20), 1'b0, 1);
                join
            end
        end
        read_page(32'hE070_0000, 1'b0, 0);

`ifdef CHNBUF_RD_ABORT_EN
        wr_page(32'hF000_0000);
        pulse_done();
        wr_page(32'hF100_0000);
        pulse_done();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.rd_en = 1'b1;
            exp_q.push_back(32'hF000_0000 + 32'(i));
            tick();
        end
        bus.rd_en    = 1'b0;
        bus.rd_abort = 1'b1;
        tick();
        bus.rd_abort = 1'b0;
        tick();
        chk("t6_abort_page_done", 64'(bus.rd_page_done), 64'd1);
        chk("t6_abort_pages_full", 64'(bus.pages_full), 64'd1);
        tick();
        read_page(32'hF100_0000, 1'b0, 0);
`endif

        repeat (5) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
